digit_uart_tx: RTL and testbench

Downstream consumer of the results converter's character stream. Samples `dout` on each rising edge of `digit_clk` and masks it to 7-bit ASCII. Buffers the characters in a small FIFO and transmits them serially as 8N1 UART frames on `txd`. Sits between the results converter and the board-level serial debug/log port, all in the `clk` domain.

---
 rtl/digit_uart_pkg.sv | 26 ++
 rtl/digit_uart_tx_if.sv | 26 ++
 rtl/dcu_sync_fifo.sv | 47 ++++
 rtl/digit_uart_tx.sv | 186 ++++++++++++++++++
 tb/tb_digit_uart_tx.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/digit_uart_pkg.sv
// Shared types and constants for digit_uart_tx and its FIFO.
// Entry width follows DCU_CRLF_EN (flag bit stored alongside the character).
package digit_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] CHAR_MASK = 8'h7F;

  localparam logic [1:0] TAIL_CHAR = 2'd0;
  localparam logic [1:0] TAIL_CR   = 2'd1;
  localparam logic [1:0] TAIL_LF   = 2'd2;

`ifdef DCU_CRLF_EN
  localparam int unsigned ENTRY_W = 9;
`else
  localparam int unsigned ENTRY_W = 8;
`endif

endpackage

// File: rtl/digit_uart_tx_if.sv
// Character-stream and UART status bundle between the results converter side
// (master) and digit_uart_tx (slave).
interface digit_uart_tx_if #(
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic          digit_clk;
  logic [7:0]    dout;
  logic          dout_flag;
  logic          clr_ovf;
  logic          txd;
  logic          tx_busy;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  modport master (
    output digit_clk, dout, dout_flag, clr_ovf,
    input  txd, tx_busy, fifo_level, overflow
  );

  modport slave (
    input  digit_clk, dout, dout_flag, clr_ovf,
    output txd, tx_busy, fifo_level, overflow
  );
endinterface

// File: rtl/dcu_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; read data is first-word-fall-through.
module dcu_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // A write into a full FIFO is still safe when the head is leaving this cycle.
  assign wr_ok = wr_en & (~full | rd_en);
  assign rd_ok = rd_en & ~empty;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/digit_uart_tx.sv
// Buffers 7-bit ASCII characters from the results converter and sends them as
// 8N1 UART frames. Define DCU_CRLF_EN to append CR/LF after flagged characters.
module digit_uart_tx
  import digit_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input logic             clk,
  input logic             reset,
  digit_uart_tx_if.slave  bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic               dig_q;
  logic               push_q;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] entry;
  logic [ENTRY_W-1:0] rd_data;
  logic               full;
  logic               empty;
  logic [AW:0]        level;
  logic               pop;
  logic               ovf;

  tx_state_t          state, state_n;
  logic [BW-1:0]      baud_cnt, baud_n;
  logic [2:0]         bit_cnt, bit_n;
  logic [7:0]         shreg, sh_n;
  logic               baud_end;
  logic               txd;
`ifdef DCU_CRLF_EN
  logic [1:0]         tail_idx, tail_n;
  logic               tail_req, req_n;

  assign entry = {bus.dout_flag, bus.dout & CHAR_MASK};
`else
  assign entry = bus.dout & CHAR_MASK;
`endif

  // Registered push: the FIFO write lands one cycle after the strobe is seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dig_q     <= 1'b0;
      push_q    <= 1'b0;
      push_data <= '0;
    end else begin
      dig_q  <= bus.digit_clk;
      push_q <= bus.digit_clk & ~dig_q;
      if (bus.digit_clk & ~dig_q) push_data <= entry;
    end
  end

  dcu_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (push_q),
    .wr_data (push_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (push_q && full && !pop) begin
      ovf <= 1'b1;
    end else if (bus.clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef DCU_CRLF_EN
      tail_idx <= TAIL_CHAR;
      tail_req <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shreg    <= sh_n;
`ifdef DCU_CRLF_EN
      tail_idx <= tail_n;
      tail_req <= req_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    baud_n   = baud_cnt;
    bit_n    = bit_cnt;
    sh_n     = shreg;
    pop      = 1'b0;
    baud_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));
`ifdef DCU_CRLF_EN
    tail_n   = tail_idx;
    req_n    = tail_req;
`endif
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_n    = rd_data[7:0];
          baud_n  = '0;
          state_n = START;
`ifdef DCU_CRLF_EN
          req_n   = rd_data[8];
          tail_n  = TAIL_CHAR;
`endif
        end
      end
      START: begin
        if (baud_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n = '0;
          sh_n   = {1'b0, shreg[7:1]};
          if (bit_cnt == 3'd7) state_n = STOP;
          else                 bit_n   = bit_cnt + 1'b1;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n  = '0;
          state_n = IDLE;
`ifdef DCU_CRLF_EN
          // Tail frames chain straight into START without touching the FIFO.
          if (tail_idx == TAIL_CHAR && tail_req) begin
            sh_n    = ASCII_CR;
            tail_n  = TAIL_CR;
            state_n = START;
          end else if (tail_idx == TAIL_CR) begin
            sh_n    = ASCII_LF;
            tail_n  = TAIL_LF;
            state_n = START;
          end else begin
            tail_n  = TAIL_CHAR;
            req_n   = 1'b0;
          end
`endif
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (state)
      START:   txd = 1'b0;
      DATA:    txd = shreg[0];
      default: txd = 1'b1;
    endcase
  end

  assign bus.txd        = txd;
  assign bus.tx_busy    = (state != IDLE);
  assign bus.fifo_level = level;
  assign bus.overflow   = ovf;

endmodule

// File: tb/tb_digit_uart_tx.sv
// Directed bench for digit_uart_tx: table of single-character frames plus
// hand-written latency, overflow, reset and (with DCU_CRLF_EN) CR/LF sequences.
module tb_digit_uart_tx;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CPB   = 16;
  localparam int          FLEN  = 10 * CPB;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  digit_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  digit_uart_tx #(
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] dout;
    logic       flag;
    int         hold;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_char(input logic [7:0] d, input logic f, input int hold);
    @(negedge clk);
    bus.digit_clk = 1'b1;
    bus.dout      = d;
    bus.dout_flag = f;
    repeat (hold) @(negedge clk);
    bus.digit_clk = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then samples nfr contiguous frames.
  task automatic recv(input int nfr, output logic [2:0][7:0] bytes, output int frame_err,
                      output int busy_cnt, output logic busy_after, output logic found);
    int f;
    int b;
    found = 1'b0; frame_err = 0; busy_cnt = 0; bytes = '0; busy_after = 1'b1;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (bus.txd === 1'b0) found = 1'b1;
    end
    if (!found) return;
    for (int s = 0; s < nfr * FLEN; s++) begin
      if (s > 0) @(negedge clk);
      if (bus.tx_busy === 1'b1) busy_cnt++;
      if (s % CPB == CPB / 2) begin
        f = s / FLEN;
        b = (s / CPB) % 10;
        if (b == 0)      begin if (bus.txd !== 1'b0) frame_err++; end
        else if (b == 9) begin if (bus.txd !== 1'b1) frame_err++; end
        else bytes[f][b-1] = bus.txd;
      end
    end
    @(negedge clk);
    busy_after = bus.tx_busy;
  endtask

  task automatic quiet(input int cycles, output int bad);
    bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.txd !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
    end
  endtask

  logic [2:0][7:0] rx;
  int              ferr, bcnt, bad;
  logic            bafter, found;

  initial begin
    vecs.push_back('{8'h35, 1'b0, 1,   8'h35});
    vecs.push_back('{8'hB1, 1'b0, 1,   8'h31});
    vecs.push_back('{8'h41, 1'b0, 500, 8'h41});
    vecs.push_back('{8'hFF, 1'b0, 2,   8'h7F});
    vecs.push_back('{8'h80, 1'b0, 1,   8'h00});
`ifndef DCU_CRLF_EN
    vecs.push_back('{8'h55, 1'b1, 1,   8'h55});
`endif

    reset = 1'b0;
    bus.digit_clk = 1'b0; bus.dout = '0; bus.dout_flag = 1'b0; bus.clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", bus.txd, 1);
    check("rst_busy", bus.tx_busy, 0);
    check("rst_level", bus.fifo_level, 0);
    check("rst_ovf", bus.overflow, 0);
    reset = 1'b1;
    quiet(1000, bad);
    check("idle_hold", bad, 0);
    check("idle_level", bus.fifo_level, 0);

    // Push/pop latency around the strobe edge.
    @(negedge clk);
    bus.digit_clk = 1'b1; bus.dout = 8'h30;
    @(negedge clk);
    bus.digit_clk = 1'b0;
    check("lat_e0_level", bus.fifo_level, 0);
    @(negedge clk);
    check("lat_e1_level", bus.fifo_level, 1);
    check("lat_e1_txd", bus.txd, 1);
    @(negedge clk);
    check("lat_e2_level", bus.fifo_level, 0);
    check("lat_e2_txd", bus.txd, 0);
    check("lat_e2_busy", bus.tx_busy, 1);
    repeat (FLEN) @(negedge clk);
    check("lat_done_busy", bus.tx_busy, 0);

    foreach (vecs[i]) begin
      fork
        push_char(vecs[i].dout, vecs[i].flag, vecs[i].hold);
        recv(1, rx, ferr, bcnt, bafter, found);
      join
      check($sformatf("v%0d_found", i), found, 1);
      check($sformatf("v%0d_framing", i), ferr, 0);
      check($sformatf("v%0d_byte", i), rx[0], vecs[i].exp);
      check($sformatf("v%0d_busy_len", i), bcnt, FLEN);
      check($sformatf("v%0d_busy_after", i), bafter, 0);
      quiet(200, bad);
      check($sformatf("v%0d_no_extra", i), bad, 0);
    end

`ifdef DCU_CRLF_EN
    fork
      push_char(8'h39, 1'b1, 1);
      recv(3, rx, ferr, bcnt, bafter, found);
    join
    check("crlf_found", found, 1);
    check("crlf_framing", ferr, 0);
    check("crlf_b0", rx[0], 8'h39);
    check("crlf_b1", rx[1], 8'h0D);
    check("crlf_b2", rx[2], 8'h0A);
    check("crlf_busy_len", bcnt, 3 * FLEN);
    check("crlf_busy_after", bafter, 0);
    quiet(200, bad);
    check("crlf_no_extra", bad, 0);
`endif

    // 18 pushes every 4 cycles into a 16-deep FIFO while frame 1 is on the line.
    fork
      begin
        for (int k = 1; k <= 18; k++) begin
          @(negedge clk);
          bus.digit_clk = 1'b1; bus.dout = 8'(8'h40 + k); bus.dout_flag = 1'b0;
          @(negedge clk);
          bus.digit_clk = 1'b0;
          repeat (2) @(negedge clk);
        end
        @(negedge clk);
        check("ovf_level", bus.fifo_level, 16);
        check("ovf_set", bus.overflow, 1);
        bus.clr_ovf = 1'b1;
        @(negedge clk);
        bus.clr_ovf = 1'b0;
        check("ovf_cleared", bus.overflow, 0);
        check("ovf_level_kept", bus.fifo_level, 16);
      end
      recv(1, rx, ferr, bcnt, bafter, found);
    join
    check("q1_found", found, 1);
    check("q1_byte", rx[0], 8'h41);
    recv(1, rx, ferr, bcnt, bafter, found);
    check("q2_found", found, 1);
    check("q2_byte", rx[0], 8'h42);
    check("q2_framing", ferr, 0);

    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.txd === 1'b0) found = 1'b1;
    end
    check("q3_found", found, 1);
    repeat (CPB + 40) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_txd", bus.txd, 1);
    check("rst_mid_busy", bus.tx_busy, 0);
    check("rst_mid_level", bus.fifo_level, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_level", bus.fifo_level, 0);
    quiet(400, bad);
    check("post_rst_quiet", bad, 0);

    fork
      push_char(8'hDA, 1'b0, 1);
      recv(1, rx, ferr, bcnt, bafter, found);
    join
    check("recover_found", found, 1);
    check("recover_byte", rx[0], 8'h5A);
    check("recover_busy_len", bcnt, FLEN);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
